test_end_monitor: RTL and testbench

TEST_END_MONITOR -- requirements
Module: test_end_monitor

---
 rtl/tb_ctrl_pkg.sv | 16 +
 rtl/test_end_monitor_ch_arbiter.sv | 30 +++
 rtl/test_end_monitor.sv | 182 ++++++++++++++++++
 tb/tb_test_end_monitor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tb_ctrl_pkg.sv
// Shared FSM state type and default event-code layout for the test end monitor.
package tb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_DELAY = 2'd0,
    ST_PULSE = 2'd1,
    ST_RUN   = 2'd2,
    ST_END   = 2'd3
  } tem_state_e;

  localparam int DEF_CODE_W   = 6;
  localparam int DEF_PASS_BIT = 5;
  localparam int DEF_FAIL_BIT = 4;
  localparam int CH_IDX_W     = 4;

endpackage

// File: rtl/test_end_monitor_ch_arbiter.sv
// Combinational priority pick: any failing hit beats passing hits, lowest index wins within a class.
module ch_arbiter
  import tb_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]   pass_hit,
  input  logic [NUM_CH-1:0]   fail_hit,
  output logic                valid,
  output logic                fail,
  output logic [CH_IDX_W-1:0] index
);

  logic [CH_IDX_W-1:0] pass_idx_s;
  logic [CH_IDX_W-1:0] fail_idx_s;

  // Scan from the top so the lowest asserted index is the last one written.
  always_comb begin
    pass_idx_s = '0;
    fail_idx_s = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pass_idx_s = pass_hit[i] ? CH_IDX_W'(i) : pass_idx_s;
      fail_idx_s = fail_hit[i] ? CH_IDX_W'(i) : fail_idx_s;
    end
    valid = (|pass_hit) | (|fail_hit);
    fail  = |fail_hit;
    index = fail ? fail_idx_s : pass_idx_s;
  end

endmodule

// File: rtl/test_end_monitor.sv
// Test end monitor: delayed DUT reset pulse, periodic channel sampling, pass/fail/timeout latch.
// Optional heartbeat output enabled by defining TEST_END_MONITOR_HEARTBEAT_EN.
module test_end_monitor
  import tb_ctrl_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CODE_W        = DEF_CODE_W,
  parameter int PASS_BIT      = DEF_PASS_BIT,
  parameter int FAIL_BIT      = DEF_FAIL_BIT,
  parameter int RST_DELAY     = 6000,
  parameter int RST_WIDTH     = 500,
  parameter int SAMPLE_PERIOD = 10000,
  parameter int TIMEOUT       = 60000000,
  parameter int CNT_W         = 32
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ev_valid,
  input  logic [NUM_CH*CODE_W-1:0] ev_code,
  output logic                     dut_rst_btn,
  output logic                     done,
  output logic                     pass,
  output logic                     timed_out,
  output logic [3:0]               hit_ch,
  output logic [CNT_W-1:0]         run_cycles
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
  ,
  output logic                     heartbeat
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(RST_DELAY - 1);
  localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(RST_WIDTH - 1);
  localparam logic [CNT_W-1:0] SAMP_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  tem_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    samp_q, samp_d;
  logic [CNT_W-1:0]    run_q, run_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                to_q, to_d;
  logic [3:0]          hit_ch_q, hit_ch_d;
  logic                btn_q, btn_d;
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
  logic                hb_q, hb_d;
`endif

  logic [NUM_CH-1:0]   pass_hit_s;
  logic [NUM_CH-1:0]   fail_hit_s;
  logic                arb_valid_s;
  logic                arb_fail_s;
  logic [CH_IDX_W-1:0] arb_idx_s;
  logic                wrap_s;
  logic                hit_s;

  // Per-channel hit classification; a code with both bits set is a failing hit.
  always_comb begin
    pass_hit_s = '0;
    fail_hit_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_hit_s[i] = ev_valid[i] & ev_code[i*CODE_W + PASS_BIT] & ~ev_code[i*CODE_W + FAIL_BIT];
      fail_hit_s[i] = ev_valid[i] & ev_code[i*CODE_W + FAIL_BIT];
    end
  end

  ch_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pass_hit (pass_hit_s),
    .fail_hit (fail_hit_s),
    .valid    (arb_valid_s),
    .fail     (arb_fail_s),
    .index    (arb_idx_s)
  );

  assign wrap_s = (state_q == ST_RUN) && (samp_q == SAMP_LAST);
  assign hit_s  = wrap_s & arb_valid_s;

  // Next-state and output logic; END holds everything by falling through to the defaults.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    samp_d   = samp_q;
    run_d    = run_q;
    done_d   = done_q;
    pass_d   = pass_q;
    to_d     = to_q;
    hit_ch_d = hit_ch_q;
    case (state_q)
      ST_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == WIDTH_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        run_d  = (run_q == CNT_MAX) ? run_q : run_q + CNT_ONE;
        samp_d = wrap_s ? '0 : samp_q + CNT_ONE;
        // A hit on the timeout cycle takes precedence over the timeout.
        if (hit_s) begin
          state_d  = ST_END;
          done_d   = 1'b1;
          pass_d   = ~arb_fail_s;
          to_d     = 1'b0;
          hit_ch_d = 4'(arb_idx_s);
        end else if (run_d == TIMEOUT_C) begin
          state_d  = ST_END;
          done_d   = 1'b1;
          pass_d   = 1'b0;
          to_d     = 1'b1;
          hit_ch_d = 4'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: begin
        state_d = ST_DELAY;
      end
    endcase
    btn_d = (state_d == ST_PULSE);
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
    hb_d = wrap_s ? ~hb_q : hb_q;
`endif
  end

  // State and output registers; the async reset also drops a pulse in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_DELAY;
      cnt_q    <= '0;
      samp_q   <= '0;
      run_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      to_q     <= 1'b0;
      hit_ch_q <= 4'd0;
      btn_q    <= 1'b0;
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
      hb_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      samp_q   <= samp_d;
      run_q    <= run_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      to_q     <= to_d;
      hit_ch_q <= hit_ch_d;
      btn_q    <= btn_d;
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
      hb_q     <= hb_d;
`endif
    end
  end

  assign dut_rst_btn = btn_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = to_q;
  assign hit_ch      = hit_ch_q;
  assign run_cycles  = run_q;
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
  assign heartbeat   = hb_q;
`endif

endmodule

// File: tb/tb_test_end_monitor.sv
// Directed bench for test_end_monitor: two instances (TIMEOUT 20 and 8) share clock, reset and events.
module tb_test_end_monitor;

  localparam int NCH = 4;
  localparam int CW  = 6;

  logic            clock = 1'b0;
  logic            resetn;
  logic [NCH-1:0]  ev_valid;
  logic [NCH*CW-1:0] ev_code;

  logic        a_btn, a_done, a_pass, a_to;
  logic [3:0]  a_hit;
  logic [31:0] a_run;
  logic        b_btn, b_done, b_pass, b_to;
  logic [3:0]  b_hit;
  logic [31:0] b_run;
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
  logic        a_hb, b_hb;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  test_end_monitor #(
    .NUM_CH(NCH), .CODE_W(CW), .PASS_BIT(5), .FAIL_BIT(4),
    .RST_DELAY(10), .RST_WIDTH(3), .SAMPLE_PERIOD(4), .TIMEOUT(20), .CNT_W(32)
  ) dut_a (
    .clock(clock), .resetn(resetn), .ev_valid(ev_valid), .ev_code(ev_code),
    .dut_rst_btn(a_btn), .done(a_done), .pass(a_pass), .timed_out(a_to),
    .hit_ch(a_hit), .run_cycles(a_run)
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
    , .heartbeat(a_hb)
`endif
  );

  test_end_monitor #(
    .NUM_CH(NCH), .CODE_W(CW), .PASS_BIT(5), .FAIL_BIT(4),
    .RST_DELAY(10), .RST_WIDTH(3), .SAMPLE_PERIOD(4), .TIMEOUT(8), .CNT_W(32)
  ) dut_b (
    .clock(clock), .resetn(resetn), .ev_valid(ev_valid), .ev_code(ev_code),
    .dut_rst_btn(b_btn), .done(b_done), .pass(b_pass), .timed_out(b_to),
    .hit_ch(b_hit), .run_cycles(b_run)
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
    , .heartbeat(b_hb)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [CW-1:0] code);
    ev_valid[ch] = v;
    ev_code[ch*CW +: CW] = code;
  endtask

  // Reset both DUTs and release on a falling edge; that half-cycle is cycle 0.
  task automatic start_run();
    ev_valid = '0;
    ev_code  = '0;
    resetn   = 1'b0;
    step(2);
    resetn   = 1'b1;
  endtask

  initial begin
    resetn   = 1'b0;
    ev_valid = '0;
    ev_code  = '0;
    step(2);
    check_eq("rst_btn",  a_btn,  0);
    check_eq("rst_done", a_done, 0);
    check_eq("rst_pass", a_pass, 0);
    check_eq("rst_to",   a_to,   0);
    check_eq("rst_hit",  a_hit,  0);
    check_eq("rst_run",  a_run,  0);

    // Reset pulse window, then timeout with no events on both instances.
    resetn = 1'b1;
    check_eq("btn_c0", a_btn, 0);
    for (int c = 1; c < 16; c++) begin
      step(1);
      check_eq($sformatf("btn_c%0d", c), a_btn, (c >= 10 && c <= 12) ? 1 : 0);
    end
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
    check_eq("hb_idle", a_hb, 0);
`endif
    step(5);
    check_eq("b_done_c20", b_done, 0);
    step(1);
    check_eq("b_to_done", b_done, 1);
    check_eq("b_to_flag", b_to,   1);
    check_eq("b_to_run",  b_run,  8);
    step(11);
    check_eq("a_done_c32", a_done, 0);
    step(1);
    check_eq("to_done", a_done, 1);
    check_eq("to_flag", a_to,   1);
    check_eq("to_pass", a_pass, 0);
    check_eq("to_hit",  a_hit,  0);
    check_eq("to_run",  a_run,  20);
`ifdef TEST_END_MONITOR_HEARTBEAT_EN
    check_eq("hb_wraps", a_hb, 1);
`endif
    step(5);
    check_eq("to_run_frozen", a_run,  20);
    check_eq("to_done_hold",  a_done, 1);

    // Passing event on ch2 held across the first sample wrap (cycle 16).
    start_run();
    set_ch(2, 1'b1, 6'b100000);
    step(16);
    check_eq("p_done_c16", a_done, 0);
    step(1);
    check_eq("p_done", a_done, 1);
    check_eq("p_pass", a_pass, 1);
    check_eq("p_hit",  a_hit,  2);
    check_eq("p_to",   a_to,   0);
    check_eq("p_run",  a_run,  4);
    set_ch(2, 1'b0, 6'b000000);
    step(4);
    check_eq("p_hold_done", a_done, 1);
    check_eq("p_hold_hit",  a_hit,  2);
    check_eq("p_hold_btn",  a_btn,  0);

    // Fail on ch3 beats pass on ch1.
    start_run();
    set_ch(1, 1'b1, 6'b100000);
    set_ch(3, 1'b1, 6'b010000);
    step(17);
    check_eq("fp_done", a_done, 1);
    check_eq("fp_pass", a_pass, 0);
    check_eq("fp_hit",  a_hit,  3);

    // Both bits set on ch2 counts as failing, beating pass on ch0.
    start_run();
    set_ch(0, 1'b1, 6'b100000);
    set_ch(2, 1'b1, 6'b110000);
    step(17);
    check_eq("both_pass", a_pass, 0);
    check_eq("both_hit",  a_hit,  2);

    // Two failing channels: lowest index wins.
    start_run();
    set_ch(0, 1'b1, 6'b100000);
    set_ch(1, 1'b1, 6'b010000);
    set_ch(3, 1'b1, 6'b010000);
    step(17);
    check_eq("low_pass", a_pass, 0);
    check_eq("low_hit",  a_hit,  1);

    // PASS only on a non-wrap cycle, and a code with neither bit, never end the test.
    start_run();
    step(17);
    set_ch(0, 1'b1, 6'b100000);
    set_ch(1, 1'b1, 6'b001111);
    step(1);
    set_ch(0, 1'b0, 6'b000000);
    step(7);
    check_eq("nosamp_done", a_done, 0);

    // Reset in the middle of the pulse drops it at once and restarts DELAY.
    start_run();
    step(11);
    check_eq("mid_btn_hi", a_btn, 1);
    resetn = 1'b0;
    #1;
    check_eq("mid_btn_async", a_btn, 0);
    step(1);
    resetn = 1'b1;
    step(9);
    check_eq("re_btn_c9", a_btn, 0);
    step(1);
    check_eq("re_btn_c10", a_btn, 1);
    step(3);
    check_eq("re_btn_c13", a_btn, 0);

    // Hit on the very wrap cycle where dut_b times out (cycle 20).
    start_run();
    step(20);
    check_eq("tie_done_c20", b_done, 0);
    set_ch(1, 1'b1, 6'b100000);
    step(1);
    set_ch(1, 1'b0, 6'b000000);
    check_eq("tie_done", b_done, 1);
    check_eq("tie_pass", b_pass, 1);
    check_eq("tie_to",   b_to,   0);
    check_eq("tie_hit",  b_hit,  1);
    check_eq("tie_run",  b_run,  8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
